// File: rtl/soml_pkg.sv
// Shared constants for the SOML front end: data defaults, frame layout and
// issue FSM state encoding.
package soml_pkg;

  localparam int unsigned N_DEF       = 32;
  localparam int unsigned Q_DEF       = 22;
  localparam int unsigned FRAME_WORDS = 24;
  localparam int unsigned H_WORDS     = 16;
  localparam int unsigned Y_WORDS     = 8;
  localparam int unsigned CNT_AW      = 5;
  localparam int unsigned IDX_W       = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_GAP   = 3'd2;
  localparam logic [2:0] ST_ISSUE = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;

endpackage

// File: rtl/soml_frame_bank.sv
// Ping-pong frame store: two banks of 24 complex words, one write port and one
// registered read address that returns H entry idx and Y entry 16+idx together.
module soml_frame_bank
  import soml_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic                wr_bank,
  input  logic [CNT_AW-1:0]   wr_addr,
  input  logic [2*N-1:0]      wr_data,
  input  logic                rd_bank,
  input  logic [IDX_W-1:0]    rd_addr,
  input  logic                rd_en_h,
  input  logic                rd_en_y,
  output logic [2*N-1:0]      h_data,
  output logic [2*N-1:0]      y_data
);

  logic [2*N-1:0] mem [2][FRAME_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_addr] <= wr_data;
  end

  // Read registers double as the output data buses, so they hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_data <= '0;
      y_data <= '0;
    end else begin
      if (rd_en_h) h_data <= mem[rd_bank][{1'b0, rd_addr}];
      if (rd_en_y) y_data <= mem[rd_bank][{2'b10, rd_addr[2:0]}];
    end
  end

endmodule

// File: rtl/soml_frame_loader.sv
// Buffers 24-word frames into a ping-pong store and replays them to the SOML
// decoder one at a time, waiting for its done (or a timeout) between frames.
module soml_frame_loader
  import soml_pkg::*;
#(
  parameter int unsigned N       = N_DEF,
  parameter int unsigned Q       = Q_DEF,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic         s_last,
  input  logic [N-1:0] s_r,
  input  logic [N-1:0] s_i,
  output logic         start,
  output logic         H_in_valid,
  output logic [N-1:0] H_in_r,
  output logic [N-1:0] H_in_i,
  output logic         Y_in_valid,
  output logic [N-1:0] Y_in_r,
  output logic [N-1:0] Y_in_i,
  input  logic         dec_done,
  output logic         busy,
  output logic         frame_err,
  output logic         timeout_err
);

  if (Q >= N || TIMEOUT < 2 || (TIMEOUT >> CNT_W) != 0) begin : g_bad_params
    $error("soml_frame_loader: Q must be below N and TIMEOUT must fit CNT_W bits");
  end

  localparam logic [CNT_W-1:0]  TMAX      = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_AW-1:0] LAST_WORD = CNT_AW'(FRAME_WORDS - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(H_WORDS - 1);
  localparam logic [IDX_W-1:0]  Y_LIMIT   = IDX_W'(Y_WORDS);

  logic [2:0]        state, next_state;
  logic [IDX_W-1:0]  idx, next_idx_c;
  logic [CNT_W-1:0]  timer;
  logic [1:0]        full, full_n;
  logic              wr_bank, wr_bank_n, rd_bank;
  logic [CNT_AW-1:0] wr_cnt;
  logic              accept_c, last_word_c, frame_ok_c, frame_bad_c, release_c;
  logic              start_c, h_valid_c, y_valid_c, busy_c, timeout_c;
  logic [2*N-1:0]    h_data, y_data;

  assign accept_c    = s_valid && s_ready;
  assign last_word_c = (wr_cnt == LAST_WORD);
  assign frame_ok_c  = accept_c && s_last && last_word_c;
  assign frame_bad_c = accept_c && (s_last != last_word_c);
  assign release_c   = (state == ST_WAIT) && (dec_done || timer == TMAX);

  // Fill and release always hit different banks, so both may land on one edge.
  always_comb begin
    full_n    = full;
    wr_bank_n = wr_bank;
    if (release_c) full_n[rd_bank] = 1'b0;
    if (frame_ok_c) begin
      full_n[wr_bank] = 1'b1;
      wr_bank_n       = ~wr_bank;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full      <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_cnt    <= '0;
      s_ready   <= 1'b1;
      frame_err <= 1'b0;
    end else begin
      full      <= full_n;
      wr_bank   <= wr_bank_n;
      rd_bank   <= rd_bank ^ release_c;
      s_ready   <= ~full_n[wr_bank_n];
      frame_err <= frame_bad_c;
      if (accept_c) wr_cnt <= (s_last || last_word_c) ? '0 : wr_cnt + CNT_AW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (full[rd_bank]) next_state = ST_START;
      ST_START: next_state = ST_GAP;
      ST_GAP:   next_state = ST_ISSUE;
      ST_ISSUE: if (idx == LAST_IDX) next_state = ST_WAIT;
      ST_WAIT:  if (release_c) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Outputs are decoded from next_state so the registered copies line up with
  // the state; the bank read address runs one entry ahead of the H/Y outputs.
  always_comb begin
    start_c    = 1'b0;
    h_valid_c  = 1'b0;
    y_valid_c  = 1'b0;
    busy_c     = 1'b0;
    timeout_c  = 1'b0;
    next_idx_c = '0;
    if (state == ST_ISSUE) next_idx_c = idx + IDX_W'(1);
    start_c   = (next_state == ST_START);
    h_valid_c = (next_state == ST_ISSUE);
    y_valid_c = h_valid_c && (next_idx_c < Y_LIMIT);
    busy_c    = (next_state != ST_IDLE);
    timeout_c = (state == ST_WAIT) && !dec_done && (timer == TMAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx         <= '0;
      timer       <= '0;
      start       <= 1'b0;
      H_in_valid  <= 1'b0;
      Y_in_valid  <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      idx         <= next_idx_c;
      timer       <= (state == ST_WAIT) ? timer + CNT_W'(1) : '0;
      start       <= start_c;
      H_in_valid  <= h_valid_c;
      Y_in_valid  <= y_valid_c;
      busy        <= busy_c;
      timeout_err <= timeout_c;
    end
  end

  soml_frame_bank #(.N(N)) u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept_c),
    .wr_bank (wr_bank),
    .wr_addr (wr_cnt),
    .wr_data ({s_r, s_i}),
    .rd_bank (rd_bank),
    .rd_addr (next_idx_c),
    .rd_en_h (h_valid_c),
    .rd_en_y (y_valid_c),
    .h_data  (h_data),
    .y_data  (y_data)
  );

  assign H_in_r = h_data[2*N-1:N];
  assign H_in_i = h_data[N-1:0];
  assign Y_in_r = y_data[2*N-1:N];
  assign Y_in_i = y_data[N-1:0];

endmodule

// File: tb/tb_soml_frame_loader.sv
// Directed bench for soml_frame_loader: a main instance (long timeout) and a
// second instance with TIMEOUT=16 and no decoder done, fed the same stream.
module tb_soml_frame_loader;

  logic        clk, rst, s_valid, s_last, dec_done, no_done;
  logic [31:0] s_r, s_i;
  logic        s_ready, start, H_in_valid, Y_in_valid, busy, frame_err, timeout_err;
  logic [31:0] H_in_r, H_in_i, Y_in_r, Y_in_i;
  logic        t_s_ready, t_start, t_H_in_valid, t_Y_in_valid, t_busy, t_frame_err, t_timeout_err;
  logic [31:0] t_H_in_r, t_H_in_i, t_Y_in_r, t_Y_in_i;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int          start_q[$], hc_q[$], yc_q[$], fe_q[$];
  logic [63:0] h_q[$], y_q[$];
  int          t_start_q[$], t_hc_q[$], t_to_q[$];
  logic [63:0] t_h_q[$];

  soml_frame_loader #(.N(32), .Q(22), .TIMEOUT(1024), .CNT_W(11)) u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .s_r(s_r), .s_i(s_i), .start(start), .H_in_valid(H_in_valid), .H_in_r(H_in_r),
    .H_in_i(H_in_i), .Y_in_valid(Y_in_valid), .Y_in_r(Y_in_r), .Y_in_i(Y_in_i),
    .dec_done(dec_done), .busy(busy), .frame_err(frame_err), .timeout_err(timeout_err)
  );

  soml_frame_loader #(.N(32), .Q(22), .TIMEOUT(16), .CNT_W(11)) u_dut_to (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(t_s_ready), .s_last(s_last),
    .s_r(s_r), .s_i(s_i), .start(t_start), .H_in_valid(t_H_in_valid), .H_in_r(t_H_in_r),
    .H_in_i(t_H_in_i), .Y_in_valid(t_Y_in_valid), .Y_in_r(t_Y_in_r), .Y_in_i(t_Y_in_i),
    .dec_done(no_done), .busy(t_busy), .frame_err(t_frame_err), .timeout_err(t_timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (start) start_q.push_back(cyc);
      if (H_in_valid) begin h_q.push_back({H_in_r, H_in_i}); hc_q.push_back(cyc); end
      if (Y_in_valid) begin y_q.push_back({Y_in_r, Y_in_i}); yc_q.push_back(cyc); end
      if (frame_err) fe_q.push_back(cyc);
      if (t_start) t_start_q.push_back(cyc);
      if (t_H_in_valid) begin t_h_q.push_back({t_H_in_r, t_H_in_i}); t_hc_q.push_back(cyc); end
      if (t_timeout_err) t_to_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stream word w of a frame: H words (b+w+1, -(b+w+1)), Y words (b+100+m, b+m).
  function automatic logic [63:0] word_val(input int base, input int w);
    int r, im;
    if (w < 16) begin r = base + w + 1; im = -r; end
    else begin r = base + 100 + w - 16; im = base + w - 16; end
    return {32'(r), 32'(im)};
  endfunction

  task automatic clear_logs();
    start_q.delete(); hc_q.delete(); yc_q.delete(); fe_q.delete();
    h_q.delete(); y_q.delete();
    t_start_q.delete(); t_hc_q.delete(); t_to_q.delete(); t_h_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; dec_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int base, input int n_words, input int last_idx,
                            output int acc, output int stalls);
    logic [63:0] v;
    int g;
    stalls = 0;
    acc    = 0;
    for (int w = 0; w < n_words; w++) begin
      v = word_val(base, w);
      s_valid = 1'b1; s_r = v[63:32]; s_i = v[31:0]; s_last = (w == last_idx);
      g = 0;
      while (!s_ready && g < 400) begin @(negedge clk); g++; end
      check("send_ready", {63'd0, s_ready}, 64'd1);
      stalls += g;
      acc = cyc;
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_h(input int n);
    int g = 0;
    while (h_q.size() < n && g < 300) begin @(negedge clk); g++; end
    check("wait_h", {63'd0, h_q.size() >= n}, 64'd1);
  endtask

  initial begin
    int acc, acc2, st, d, g, l_cyc;
    no_done = 1'b0; s_r = '0; s_i = '0;
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; dec_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_s_ready", {63'd0, s_ready}, 64'd1);
    check("rst_ctrl", {58'd0, start, H_in_valid, Y_in_valid, busy, frame_err, timeout_err}, 64'd0);
    check("rst_h_bus", {H_in_r, H_in_i}, 64'd0);
    check("rst_y_bus", {Y_in_r, Y_in_i}, 64'd0);
    rst = 1'b0;
    clear_logs();

    // Single frame, decoder done 40 cycles after the last H.
    send_frame(0, 24, 23, acc, st);
    wait_h(16);
    check("t1_start_n", start_q.size(), 1);
    check("t1_start_cyc", start_q[0], acc + 2);
    for (int n = 0; n < 16; n++) begin
      check("t1_h", h_q[n], {32'(n + 1), 32'(-(n + 1))});
      check("t1_h_cyc", hc_q[n], acc + 4 + n);
    end
    check("t1_y_n", y_q.size(), 8);
    for (int m = 0; m < 8; m++) begin
      check("t1_y", y_q[m], {32'(100 + m), 32'(m)});
      check("t1_y_cyc", yc_q[m], acc + 4 + m);
    end
    check("t1_h_hold", {H_in_r, H_in_i}, {32'd16, 32'(-16)});
    check("t1_y_hold", {Y_in_r, Y_in_i}, {32'd107, 32'd7});
    g = 0;
    while (cyc < hc_q[15] + 40 && g < 100) begin @(negedge clk); g++; end
    dec_done = 1'b1;
    check("t1_busy_before", {63'd0, busy}, 64'd1);
    @(negedge clk);
    dec_done = 1'b0;
    check("t1_busy_after", {63'd0, busy}, 64'd0);
    check("t1_no_timeout", {63'd0, timeout_err}, 64'd0);

    // Two back-to-back frames, then both banks full.
    do_reset();
    send_frame(32'h1000, 24, 23, acc, st);
    send_frame(32'h2000, 24, 23, acc2, st);
    check("t2_no_stall", st, 0);
    check("t2_full_stall", {63'd0, s_ready}, 64'd0);
    wait_h(16);
    idle(10);
    check("t2_one_start", start_q.size(), 1);
    check("t2_still_stalled", {63'd0, s_ready}, 64'd0);
    check("t2_h_a0", h_q[0], word_val(32'h1000, 0));
    dec_done = 1'b1;
    d = cyc;
    @(negedge clk);
    dec_done = 1'b0;
    check("t2_ready_back", {63'd0, s_ready}, 64'd1);
    wait_h(32);
    check("t2_start2_cyc", start_q[1], d + 2);
    check("t2_h_b0", h_q[16], word_val(32'h2000, 0));
    check("t2_h_b15", h_q[31], word_val(32'h2000, 15));
    check("t2_y_b0", y_q[8], word_val(32'h2000, 16));

    // Early s_last drops the frame; the next good frame still issues.
    do_reset();
    send_frame(32'h3000, 11, 10, acc, st);
    idle(2);
    check("t3_ferr_n", fe_q.size(), 1);
    check("t3_ferr_cyc", fe_q[0], acc + 1);
    idle(30);
    check("t3_no_start", start_q.size(), 0);
    send_frame(32'h3100, 24, 23, acc2, st);
    wait_h(16);
    check("t3_start_cyc", start_q[0], acc2 + 2);
    check("t3_h0", h_q[0], word_val(32'h3100, 0));
    check("t3_h15", h_q[15], word_val(32'h3100, 15));
    check("t3_y7", y_q[7], word_val(32'h3100, 23));
    check("t3_ferr_once", fe_q.size(), 1);

    // Missing s_last on word 23.
    do_reset();
    send_frame(32'h4000, 24, -1, acc, st);
    idle(2);
    check("t4_ferr_n", fe_q.size(), 1);
    check("t4_ferr_cyc", fe_q[0], acc + 1);
    idle(30);
    check("t4_no_start", start_q.size(), 0);
    check("t4_ready", {63'd0, s_ready}, 64'd1);
    check("t4_idle", {63'd0, busy}, 64'd0);

    // Timeout on the TIMEOUT=16 instance; the second frame follows it.
    do_reset();
    check("t5_rst_state", {60'd0, t_s_ready, t_busy, t_frame_err, t_Y_in_valid}, 64'h8);
    send_frame(32'h5000, 24, 23, acc, st);
    send_frame(32'h5100, 24, 23, acc2, st);
    g = 0;
    while (t_start_q.size() < 2 && g < 200) begin @(negedge clk); g++; end
    check("t5_two_starts", {63'd0, t_start_q.size() >= 2}, 64'd1);
    check("t5_start0_cyc", t_start_q[0], acc + 2);
    check("t5_h_n", {63'd0, t_hc_q.size() >= 16}, 64'd1);
    l_cyc = t_hc_q[15];
    check("t5_h0", t_h_q[0], word_val(32'h5000, 0));
    check("t5_to_n", t_to_q.size(), 1);
    check("t5_to_cyc", t_to_q[0], l_cyc + 17);
    check("t5_start1_cyc", t_start_q[1], l_cyc + 18);
    check("t5_y_hold", {t_Y_in_r, t_Y_in_i}, word_val(32'h5000, 23));

    // Reset in the middle of issue.
    do_reset();
    send_frame(0, 24, 23, acc, st);
    g = 0;
    while (!(H_in_valid && H_in_r == 32'd6) && g < 100) begin @(negedge clk); g++; end
    check("t6_reach_idx5", {63'd0, H_in_valid}, 64'd1);
    rst = 1'b1;
    #1;
    check("t6_valids", {62'd0, H_in_valid, Y_in_valid}, 64'd0);
    check("t6_ready", {63'd0, s_ready}, 64'd1);
    check("t6_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    idle(40);
    check("t6_no_start", start_q.size(), 0);
    send_frame(32'h6000, 24, 23, acc, st);
    wait_h(16);
    check("t6_start_cyc", start_q[0], acc + 2);
    check("t6_h0", h_q[0], word_val(32'h6000, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
